wshb_frame_reader: RTL
======================

Name: wshb_frame_reader

Overview:
- Wishbone classic master that continuously reads a HDISP x VDISP 32-bit-per-pixel frame buffer from SDRAM, in raster order. This is the read-side counterpart of the pattern/frame writers.
- Each returned pixel (RGB, low 24 bits) is pushed into the display pixel FIFO, which feeds the video timing generator.
- Throttles on FIFO almost-full and releases the bus periodically so writers can be arbitrated in.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BASE_ADR, 0, byte address of pixel (0,0)
- BURST, 64, max consecutive acked reads before a mandatory 1-cycle cyc release

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  level; 1 = keep streaming frames
- wshb_adr_o  out  32  byte address = BASE_ADR + 4*pixel_index
- wshb_dat_i  in  32  read data; [23:0] = {R,G,B}
- wshb_cyc_o  out  1  bus cycle
- wshb_stb_o  out  1  strobe
- wshb_we_o  out  1  constant 0
- wshb_sel_o  out  4  constant 4'b1111
- wshb_ack_i  in  1  transfer ack
- wshb_err_i  in  1  transfer error, terminates the transfer like ack
- fifo_wdata  out  24  pixel to FIFO
- fifo_write  out  1  FIFO write strobe, one pixel per cycle high
- fifo_afull  in  1  FIFO almost-full (>=2 free entries remain when asserted)
- frame_done  out  1  1-cycle pulse when the last pixel of a frame is written to the FIFO
- err_count  out  16  saturating count of err-terminated transfers

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; pixel_index=0; burst_cnt=0.
  - cyc, stb, fifo_write, frame_done, err_count = 0.
  - fifo_wdata = 0; wshb_adr_o = BASE_ADR.
  - Applies mid-transfer too: cyc/stb drop at the next edge, and any in-flight ack is discarded.
- FSM states: IDLE, REQ, GAP, WAIT.
  - IDLE: cyc=stb=0. Moves to REQ when enable=1 and fifo_afull=0. Moves to WAIT when enable=1 and fifo_afull=1.
  - REQ: cyc=stb=1, adr from pixel_index. Stays in REQ until ack|err; stb is never withdrawn before termination. On termination:
    - enable=0 -> IDLE, pixel_index=0.
    - else burst_cnt==BURST-1 -> GAP.
    - else fifo_afull=1 -> WAIT.
    - else remain in REQ with the next address (back-to-back, one transfer per ack).
  - GAP: cyc=stb=0 for exactly 1 cycle; burst_cnt=0. Then goes to REQ, WAIT or IDLE using the same enable/fifo_afull rules as IDLE.
  - WAIT: cyc=stb=0. Moves to REQ when fifo_afull=0; moves to IDLE with pixel_index=0 when enable=0.
- Data path:
  - On an ack cycle in REQ: fifo_wdata <= wshb_dat_i[23:0] and fifo_write <= 1, giving 1-cycle latency from ack to FIFO write.
  - On an err cycle in REQ: fifo_wdata <= 0, fifo_write <= 1 (the pixel slot is preserved so raster alignment holds), err_count increments and saturates at 16'hFFFF.
  - fifo_write is 0 on every other cycle.
- Addressing:
  - pixel_index is an unsigned counter of width $clog2(HDISP*VDISP).
  - It increments on each terminated transfer.
  - When index HDISP*VDISP-1 terminates, it wraps to 0 and frame_done pulses in the same cycle as that pixel's fifo_write.
  - Address arithmetic is 32-bit: BASE_ADR + (pixel_index << 2).
- Simultaneous events:
  - fifo_afull rising in the same cycle as an ack: that transfer completes and its pixel is written; the FSM then goes to WAIT. The FIFO slack guarantees no overflow.
  - Burst end coincides with afull: GAP takes priority, then WAIT.
  - enable=0 during REQ: the current transfer completes and its pixel is written; the next enable restarts at pixel 0 and no frame_done is issued.
- Single outstanding transfer only; no pipelined Wishbone.

Decomposition:
- Shared package video_pkg: pixel_t (24-bit RGB), WB_SEL_ALL, and the frame-size helper function NPIX(HDISP,VDISP).
- FSM state enum stays local to the module.
- One natural sub-module: wshb_frame_addr_gen, holding pixel_index, wrap detection, burst_cnt and the address output.

Test Plan:
- HDISP=8, VDISP=4, BURST=64, slave acks every cycle, afull=0 -> 32 fifo_write strobes; addresses 0x00..0x7C; frame_done exactly on pixel 31; next read is address 0x00.
- BURST=4, zero-wait slave -> cyc low for exactly 1 cycle after every 4th ack; no pixel lost or duplicated across 2 frames.
- Slave with 3 wait states, dat_i = address -> each fifo_wdata equals the low 24 bits of its address; fifo_write comes 1 cycle after ack.
- Assert afull coincident with the ack of pixel 5 -> pixel 5 is written; cyc=0 until afull drops; resumes at address 0x18.
- err on pixel 10 -> fifo_wdata=0 for that slot; err_count=1; pixels 11+ are normal.
- rst_n=0 while stb is high, then enable=0 mid-frame, then re-enable -> outputs 0 next edge; restart at BASE_ADR; no frame_done.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared pixel type, Wishbone byte-select constant and frame-size helper
package video_pkg;
    typedef logic [23:0] pixel_t;
    localparam logic [3:0] WB_SEL_ALL = 4'b1111;
    function automatic int unsigned NPIX(input int unsigned hdisp, input int unsigned vdisp);
        return hdisp * vdisp;
    endfunction
endpackage

// File: rtl/wshb_frame_addr_gen.sv
// wshb_frame_addr_gen: raster pixel index, frame wrap, burst length count and read address
module wshb_frame_addr_gen
    import video_pkg::*;
#(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter int unsigned BURST = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        idx_clr,
    input  logic        burst_clr,
    output logic [31:0] adr,
    output logic        last,
    output logic        burst_end
);
    localparam int unsigned NP = NPIX(HDISP, VDISP);
    localparam int unsigned IW = NP > 1 ? $clog2(NP) : 1;
    localparam int unsigned BW = BURST > 1 ? $clog2(BURST) : 1;
    logic [IW-1:0] pixel_index;
    logic [BW-1:0] burst_cnt;
    assign last = pixel_index == IW'(NP - 1);
    assign burst_end = burst_cnt == BW'(BURST - 1);
    assign adr = BASE_ADR + (32'(pixel_index) << 2);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_index <= '0;
            burst_cnt <= '0;
        end else begin
            pixel_index <= idx_clr ? '0 : step ? (last ? '0 : pixel_index + 1'b1) : pixel_index;
            burst_cnt <= burst_clr ? '0 : step ? (burst_end ? '0 : burst_cnt + 1'b1) : burst_cnt;
        end
    end
endmodule

// File: rtl/wshb_frame_reader.sv
// wshb_frame_reader: Wishbone classic master streaming a frame buffer into the display pixel FIFO
module wshb_frame_reader
    import video_pkg::*;
#(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter int unsigned BURST = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [31:0] wshb_adr_o,
    input  logic [31:0] wshb_dat_i,
    output logic        wshb_cyc_o,
    output logic        wshb_stb_o,
    output logic        wshb_we_o,
    output logic [3:0]  wshb_sel_o,
    input  logic        wshb_ack_i,
    input  logic        wshb_err_i,
    output pixel_t      fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_afull,
    output logic        frame_done,
    output logic [15:0] err_count
);
    typedef enum logic [1:0] {IDLE, REQ, GAP, WAIT} state_t;
    state_t state, state_nxt;
    logic term, last, burst_end;
    assign term = state == REQ && (wshb_ack_i || wshb_err_i);
    wshb_frame_addr_gen #(
        .HDISP(HDISP),
        .VDISP(VDISP),
        .BASE_ADR(BASE_ADR),
        .BURST(BURST)
    ) u_addr (
        .clk(clk),
        .rst_n(rst_n),
        .step(term),
        .idx_clr(!enable && (state != REQ || term)),
        .burst_clr(state == GAP),
        .adr(wshb_adr_o),
        .last(last),
        .burst_end(burst_end)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // Burst end wins over afull so the bus is always released before throttling
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, GAP: state_nxt = !enable ? IDLE : fifo_afull ? WAIT : REQ;
            REQ:       state_nxt = !term ? REQ : !enable ? IDLE : burst_end ? GAP : fifo_afull ? WAIT : REQ;
            WAIT:      state_nxt = !enable ? IDLE : fifo_afull ? WAIT : REQ;
            default:   state_nxt = IDLE;
        endcase
    end
    always_comb begin
        wshb_cyc_o = state == REQ;
        wshb_stb_o = state == REQ;
        wshb_we_o = 1'b0;
        wshb_sel_o = WB_SEL_ALL;
    end
    // Errored transfers still occupy a pixel slot to keep the raster aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wdata <= '0;
            fifo_write <= 1'b0;
            frame_done <= 1'b0;
            err_count <= '0;
        end else begin
            fifo_write <= term;
            frame_done <= term && last;
            if (term) fifo_wdata <= wshb_err_i ? '0 : wshb_dat_i[23:0];
            if (term && wshb_err_i && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
        end
    end
endmodule
